// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin shared signed adder; ports clk, arst, req_valid/ready/a/b per requester, res_valid/ready/sum/id, busy
module adder_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_SCALE = 0,
  parameter int OUT_WIDTH = (A_WIDTH > B_WIDTH ? A_WIDTH : B_WIDTH) + 1,
  parameter int ID_WIDTH  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [OUT_WIDTH-1:0]         res_sum,
  output logic [ID_WIDTH-1:0]          res_id,
  output logic                         busy
);
  localparam int SW = A_WIDTH + B_WIDTH;
  logic [ID_WIDTH-1:0] ptr, gnt_id;
  logic                found, grant;
  logic [A_WIDTH-1:0]  a_sel;
  logic [B_WIDTH-1:0]  b_sel;
  logic signed [SW-1:0] full, scaled;
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!found && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
        found  = 1'b1;
        gnt_id = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
      end
  end
  assign grant     = !arst && found && (!res_valid || res_ready);
  assign req_ready = grant ? (NUM_REQ'(1) << gnt_id) : '0;
  assign busy      = res_valid || |req_valid;
  assign a_sel  = req_a[gnt_id*A_WIDTH +: A_WIDTH];
  assign b_sel  = req_b[gnt_id*B_WIDTH +: B_WIDTH];
  assign full   = $signed({{B_WIDTH{a_sel[A_WIDTH-1]}}, a_sel}) + $signed({{A_WIDTH{b_sel[B_WIDTH-1]}}, b_sel});
  assign scaled = full >>> OUT_SCALE;
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_id    <= '0;
      ptr       <= '0;
    end else if (grant) begin
      res_valid <= 1'b1;
      res_sum   <= scaled[OUT_WIDTH-1:0];
      res_id    <= gnt_id;
      ptr       <= (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end else if (res_ready)
      res_valid <= 1'b0;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: table-driven and directed checks of the shared adder arbiter
module tb_adder_share_arbiter;
  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic        res_ready = 1'b0;
  logic [3:0]  req_ready, req_ready1;
  logic        res_valid, res_valid1, busy, busy1;
  logic [16:0] res_sum, res_sum1;
  logic [1:0]  res_id, res_id1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  adder_share_arbiter dut (
    .clk(clk), .arst(arst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_id(res_id), .busy(busy));
  adder_share_arbiter #(.OUT_SCALE(1)) dut1 (
    .clk(clk), .arst(arst), .req_valid(req_valid), .req_ready(req_ready1),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid1), .res_ready(res_ready),
    .res_sum(res_sum1), .res_id(res_id1), .busy(busy1));
  typedef struct packed {
    logic        rst;
    logic [3:0]  v;
    logic        rr;
    logic [3:0]  er;
    logic        ev;
    logic [1:0]  eid;
    logic [16:0] es;
  } vec_t;
  vec_t tv [17];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pulse_reset();
    arst = 1'b1;
    #1 arst = 1'b0;
  endtask
  task automatic set_default_operands();
    req_a = {16'sd305, 16'sd205, 16'sd105, 16'sd5};
    req_b = {-16'sd6, -16'sd5, -16'sd4, -16'sd3};
  endtask
  initial begin
    tv[0]  = '{1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 17'd2};
    tv[1]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 17'd0};
    tv[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 17'd2};
    tv[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 17'd101};
    tv[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 17'd200};
    tv[5]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 17'd299};
    tv[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 17'd2};
    tv[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 17'd101};
    tv[8]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 17'd101};
    tv[9]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd1, 17'd101};
    tv[10] = '{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd1, 17'd101};
    tv[11] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 17'd200};
    tv[12] = '{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 17'd101};
    tv[13] = '{1'b0, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 17'd200};
    tv[14] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 17'd2};
    tv[15] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 17'd0};
    tv[16] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 17'd101};
    set_default_operands();
    #3;
    chk("reset_valid", {31'd0, res_valid}, 32'd0);
    chk("reset_sum", {15'd0, res_sum}, 32'd0);
    chk("reset_id", {30'd0, res_id}, 32'd0);
    req_valid = 4'b1111;
    #1 chk("ready_in_reset", {28'd0, req_ready}, 32'd0);
    req_valid = '0;
    arst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) begin
      if (tv[i].rst) pulse_reset();
      req_valid = tv[i].v;
      res_ready = tv[i].rr;
      #1 chk($sformatf("v%0d_ready", i), {28'd0, req_ready}, {28'd0, tv[i].er});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, res_valid}, {31'd0, tv[i].ev});
      if (tv[i].ev) begin
        chk($sformatf("v%0d_id", i), {30'd0, res_id}, {30'd0, tv[i].eid});
        chk($sformatf("v%0d_sum", i), {15'd0, res_sum}, {15'd0, tv[i].es});
      end
    end
    pulse_reset();
    res_ready = 1'b1;
    req_a[15:0] = -16'sd7;
    req_b[15:0] = 16'sd0;
    req_valid = 4'b0001;
    @(posedge clk);
    #1 chk("scale1_neg7", {15'd0, res_sum1}, {15'd0, 17'h1FFFC});
    req_a[15:0] = 16'sd32767;
    req_b[15:0] = 16'sd32767;
    @(posedge clk);
    #1 chk("scale1_max", {15'd0, res_sum1}, 32'd32767);
    req_a[15:0] = -16'sd32768;
    req_b[15:0] = -16'sd32768;
    @(posedge clk);
    #1 chk("scale0_min", {15'd0, res_sum}, {15'd0, 17'h10000});
    req_valid = 4'b1111;
    #3 arst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, res_valid}, 32'd0);
    chk("midrst_ready", {28'd0, req_ready}, 32'd0);
    arst = 1'b0;
    #1 chk("midrst_first_grant", {28'd0, req_ready}, 32'd1);
    req_valid = 4'b0000;
    #1 chk("idle_busy", {31'd0, busy}, 32'd0);
    req_valid = 4'b0100;
    #1 chk("req_busy", {31'd0, busy}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one signed adder datapath (sum = (a + b) >>> OUT_SCALE, width max(A,B)+1) between NUM_REQ requesters.
- Used in the accelerator where several PE-row partial-sum paths need occasional additions but one adder per path is too costly.
- Round-robin arbitration with valid/ready handshakes on every request port and on the single result port.
- One registered result stage; each result is tagged with the requester id.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- A_WIDTH, 16, signed width of operand a.
- B_WIDTH, 16, signed width of operand b.
- OUT_SCALE, 0, arithmetic right shift applied to the full-precision sum.
- OUT_WIDTH, max(A_WIDTH,B_WIDTH)+1, signed result width.
- ID_WIDTH, max(1,$clog2(NUM_REQ)), requester id width (derived; do not override).

Ports:
- clk  in  1  clock; all state on rising edge.
- arst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester grant/accept; at most one bit high.
- req_a  in  NUM_REQ*A_WIDTH  packed signed operand a; requester i at bits [i*A_WIDTH +: A_WIDTH].
- req_b  in  NUM_REQ*B_WIDTH  packed signed operand b, same packing.
- res_valid  out  1  result register holds a valid sum.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  OUT_WIDTH  signed scaled sum.
- res_id  out  ID_WIDTH  index of the requester that produced res_sum.
- busy  out  1  res_valid OR any req_valid.

Behaviour:
- Reset (arst=1, asynchronous): res_valid=0, res_sum=0, res_id=0, priority pointer=0. Any pending result is discarded. req_ready is combinational and is 0 while arst=1.
- Space condition: space = !res_valid || res_ready.
- Grant: when space=1, grant the first i with req_valid[i]=1, searching circularly from the priority pointer. req_ready[i] is asserted only for that i, in the same cycle (combinational from req_valid, res_valid, res_ready).
- Handshake rules:
  - A requester's transfer occurs on a clock edge where req_valid[i] && req_ready[i].
  - req_valid must not depend on req_ready.
  - A requester holds req_valid and its operands stable until accepted.
- On a transfer at edge t:
  - res_sum and res_id are loaded and res_valid=1 after edge t (latency 1 cycle).
  - The pointer becomes (i+1) mod NUM_REQ.
- Result drain:
  - res_valid && res_ready with no new grant: res_valid drops to 0.
  - Drain and a new grant in the same cycle: the register reloads with the new result and res_valid stays 1. Throughput is 1 result/cycle.
- Backpressure: res_valid=1 and res_ready=0 means all req_ready=0. res_sum and res_id hold stable and the pointer does not move.
- No valid requests: no grant, pointer unchanged.
- Arithmetic:
  - Sign-extend a and b to A_WIDTH+B_WIDTH bits and add.
  - Arithmetic shift right by OUT_SCALE (rounds toward −inf).
  - Keep the low OUT_WIDTH bits; no saturation. With OUT_SCALE=0 and the default OUT_WIDTH, overflow cannot occur.
- Pointer wrap: after granting NUM_REQ-1, the pointer returns to 0.
- No combinational path from res_ready to res_sum, res_id or res_valid.

Test Plan:
- Single request: after reset, req_valid=0001, a0=5, b0=-3, res_ready=1. Expected: req_ready=0001 in the same cycle; next cycle res_valid=1, res_sum=2, res_id=0; the cycle after, res_valid=0.
- Full contention: req_valid=1111 held for 6 cycles, res_ready=1. Expected: grants and res_id sequence 0,1,2,3,0,1, back-to-back with no bubbles.
- Backpressure:
  - Result pending with res_ready=0 for 3 cycles: req_ready=0000 and res_sum/res_id unchanged.
  - Raise res_ready with req_valid=0100: the drain and the grant to requester 2 happen in the same cycle, and res_valid stays 1.
- Pointer skip: after a grant to requester 1, req_valid=0101. Expected: requester 2 is granted first, then requester 0.
- Scaling, OUT_SCALE=1:
  - a=-7, b=0 gives res_sum=-4.
  - a=32767, b=32767 gives 32767.
  - With OUT_SCALE=0, a=-32768, b=-32768 gives -65536 in 17 bits.
- Reset mid-stream: assert arst between clock edges while res_valid=1. Expected: res_valid=0 immediately, before the next edge. After release with req_valid=1111, requester 0 is granted first.
